// File: rtl/uart_loopback_fifo.sv
// Echo buffer between UART receiver and transmitter: circular byte FIFO filled on
// rx_done and drained one byte per tx_start/tx_busy handshake.
module uart_loopback_fifo #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            overflow_q, overflow_d;
    logic            wr_en_c;
    logic            pop_c;

    // Write side: fullness is judged on the pre-edge count, so a write racing a pop while full is dropped
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        wr_en_c  = rx_done && !full_q;
        if (wr_en_c) begin
            mem_d[wr_ptr_q] = rx_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
    end

    // Read FSM: pop in IDLE, then wait for the transmitter to take and finish the byte
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        pop_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && !tx_busy) begin
                    pop_c      = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + PW'(1);
                    tx_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A transmitter that never answers costs the byte, not the pipeline
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy and status flags, decoded from the post-edge count
    always_comb begin
        count_d = count_q;
        if (wr_en_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en_c && pop_c) begin
            count_d = count_q - CW'(1);
        end
        empty_d    = (count_d == '0);
        full_d     = (count_d == CW'(DEPTH));
        overflow_d = overflow_q | (rx_done & full_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage contents are don't-care after reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
